reg_trace_streamer: RTL and testbench

//  Debug-side producer of CPU state. On a start pulse it snapshots the PC and walks the

---
 rtl/reg_trace_streamer_pkg.sv | 44 ++++
 rtl/reg_trace_streamer.sv | 109 ++++++++++
 tb/tb_reg_trace_streamer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_trace_streamer_pkg.sv
// Shared definitions for the register trace streamer: FSM encoding, beat counter type
// and the fixed register walk order.
package reg_trace_streamer_pkg;

  localparam int TRACE_LEN = 18;
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_LOAD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef logic [CNT_W-1:0] cnt_t;

  // Walk order: $s0-$s7, then $t0-$t7, then $t8-$t9.
  function automatic logic [4:0] trace_map(input cnt_t cnt);
    logic [4:0] r;
    case (cnt)
      5'd0:    r = 5'd16;
      5'd1:    r = 5'd17;
      5'd2:    r = 5'd18;
      5'd3:    r = 5'd19;
      5'd4:    r = 5'd20;
      5'd5:    r = 5'd21;
      5'd6:    r = 5'd22;
      5'd7:    r = 5'd23;
      5'd8:    r = 5'd8;
      5'd9:    r = 5'd9;
      5'd10:   r = 5'd10;
      5'd11:   r = 5'd11;
      5'd12:   r = 5'd12;
      5'd13:   r = 5'd13;
      5'd14:   r = 5'd14;
      5'd15:   r = 5'd15;
      5'd16:   r = 5'd24;
      5'd17:   r = 5'd25;
      default: r = 5'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/reg_trace_streamer.sv
// Streams a PC header followed by the monitored register-file entries over valid/ready,
// reading the register file through one combinational read port.
module reg_trace_streamer
  import reg_trace_streamer_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_TRACE = TRACE_LEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [DATA_W-1:0] pc_i,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_is_pc,
  output logic [ADDR_W-1:0] out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  // state | meaning
  // IDLE  | waiting for start_i
  // SEND  | beat presented on out_*, waiting for handshake
  // LOAD  | register read for beat cnt, captured into out_*
  // DONE  | one-cycle done pulse, then back to IDLE

  localparam cnt_t LAST_CNT = cnt_t'(NUM_TRACE - 1);

  state_t state, state_nxt;
  cnt_t   cnt;
  logic   hs;

  assign hs = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_i) state_nxt = ST_SEND;
      ST_SEND: begin
        if (hs) begin
          if (out_is_pc)     state_nxt = ST_LOAD;
          else if (out_last) state_nxt = ST_DONE;
          else               state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: state_nxt = ST_SEND;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != ST_IDLE);
    done     = (state == ST_DONE);
    rf_raddr = '0;
    if (state == ST_LOAD) rf_raddr = ADDR_W'(trace_map(cnt));
  end

  // Beat registers; only written on the accept edge, so they stay frozen while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      out_valid <= 1'b0;
      out_is_pc <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            out_data  <= pc_i;
            out_is_pc <= 1'b1;
            out_idx   <= '0;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            cnt       <= '0;
          end
        end
        ST_SEND: begin
          if (hs) begin
            out_valid <= 1'b0;
            if (!out_is_pc && !out_last && (cnt != LAST_CNT)) cnt <= cnt + cnt_t'(1);
          end
        end
        ST_LOAD: begin
          out_data  <= rf_rdata;
          out_idx   <= ADDR_W'(trace_map(cnt));
          out_is_pc <= 1'b0;
          out_last  <= (cnt == LAST_CNT);
          out_valid <= 1'b1;
        end
        ST_DONE: out_last <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_trace_streamer.sv
// Self-checking bench for reg_trace_streamer: table of expected beats per frame plus
// directed sequences for reset abort, stalls, held start and mid-frame register writes.
module tb_reg_trace_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [31:0] pc_i;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        out_valid;
  logic        out_ready;
  logic        out_is_pc;
  logic [4:0]  out_idx;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [31:0] rf [32];
  int          cyc = 0;
  int          n_tot = 0;
  int          n_pass = 0;
  int          e0;
  logic        clear16;

  typedef struct {
    int          stall;
    logic        is_pc;
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } vec_t;

  vec_t vec [19];
  int   order [18] = '{16, 17, 18, 19, 20, 21, 22, 23, 8, 9, 10, 11, 12, 13, 14, 15, 24, 25};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rf_rdata = rf[rf_raddr];

  reg_trace_streamer dut (
    .clk(clk), .reset(reset), .start_i(start_i), .pc_i(pc_i),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_is_pc(out_is_pc),
    .out_idx(out_idx), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic rf_init();
    for (int r = 0; r < 32; r++) rf[r] = 32'h1000_0000 + r;
  endtask

  // stall_mode: 0 none, 1 random ~50%, 2 long stall on header only
  task automatic fill(input logic [31:0] pc, input int stall_mode);
    for (int i = 0; i < 19; i++) begin
      if (stall_mode == 1) vec[i].stall = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0;
      else if (stall_mode == 2 && i == 0) vec[i].stall = 100;
      else vec[i].stall = 0;
    end
    vec[0].is_pc = 1'b1; vec[0].idx = 5'd0; vec[0].data = pc; vec[0].last = 1'b0;
    for (int i = 0; i < 18; i++) begin
      vec[i+1].is_pc = 1'b0;
      vec[i+1].idx   = 5'(order[i]);
      vec[i+1].data  = 32'h1000_0000 + order[i];
      vec[i+1].last  = (i == 17);
    end
  endtask

  task automatic check_beat(input int i, input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_is_pc"}, {31'd0, out_is_pc}, {31'd0, vec[i].is_pc});
    chk({tag, "_idx"},   {27'd0, out_idx},   {27'd0, vec[i].idx});
    chk({tag, "_data"},  out_data,           vec[i].data);
    chk({tag, "_last"},  {31'd0, out_last},  {31'd0, vec[i].last});
  endtask

  task automatic start_frame(input logic [31:0] pc, input logic hold);
    @(negedge clk);
    pc_i = pc;
    start_i = 1'b1;
    @(posedge clk);
    #1 e0 = cyc;
    @(negedge clk);
    pc_i = 32'hFFFF_FFFF;
    if (!hold) start_i = 1'b0;
  endtask

  // Called at a negedge after start acceptance; ends at the negedge after done.
  task automatic consume(input int exp_lat);
    int n;
    for (int i = 0; i < 19; i++) begin
      n = 0;
      while (!out_valid && n < 8) begin
        @(negedge clk);
        n++;
      end
      if (!out_valid) begin
        chk("beat_timeout", 32'd0, 32'd1);
        return;
      end
      out_ready = (vec[i].stall == 0);
      check_beat(i, "beat");
      for (int s = 0; s < vec[i].stall; s++) begin
        @(negedge clk);
        check_beat(i, "stall");
        chk("stall_busy", {31'd0, busy}, 32'd1);
        chk("stall_raddr", {27'd0, rf_raddr}, 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      if (clear16 && !vec[i].is_pc && vec[i].idx == 5'd16) rf[16] = 32'd0;
    end
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("done_valid_low", {31'd0, out_valid}, 32'd0);
    if (exp_lat > 0) chk("done_latency", 32'(cyc - e0), 32'(exp_lat));
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int seen_done;
    reset = 1'b1; start_i = 1'b0; pc_i = '0; out_ready = 1'b1; clear16 = 1'b0;
    rf_init();
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_raddr", {27'd0, rf_raddr}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_no_start", {31'd0, busy}, 32'd0);

    // 1) reset mid-frame aborts immediately, next start gives a full frame
    fill(32'h0000_1234, 0);
    start_frame(32'h0000_1234, 1'b0);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_raddr", {27'd0, rf_raddr}, 32'd0);
    chk("abort_idx", {27'd0, out_idx}, 32'd0);
    chk("abort_data", out_data, 32'd0);
    chk("abort_last", {31'd0, out_last}, 32'd0);
    chk("abort_is_pc", {31'd0, out_is_pc}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen_done = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);
    start_frame(32'h0000_1234, 1'b0);
    consume(0);

    // 2) ready tied high, timing from start acceptance to done
    fill(32'h0040_0010, 0);
    start_frame(32'h0040_0010, 1'b0);
    consume(37);

    // 3) random stalls
    fill(32'h0040_0010, 1);
    start_frame(32'h0040_0010, 1'b0);
    consume(0);

    // 4) start held high: one frame, next header only after returning to IDLE
    fill(32'h0BAD_F00D, 0);
    start_frame(32'h0BAD_F00D, 1'b1);
    pc_i = 32'h0BAD_F00D;
    consume(0);
    chk("held_idle_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("held_restart_valid", {31'd0, out_valid}, 32'd1);
    chk("held_restart_is_pc", {31'd0, out_is_pc}, 32'd1);
    chk("held_restart_data", out_data, 32'h0BAD_F00D);
    start_i = 1'b0;
    consume(0);

    // 5) register writes during the frame are seen per beat
    fill(32'h0000_0500, 0);
    vec[9].data = 32'hDEAD_BEEF;
    clear16 = 1'b1;
    start_frame(32'h0000_0500, 1'b0);
    rf[8] = 32'hDEAD_BEEF;
    consume(0);
    clear16 = 1'b0;
    chk("rf16_cleared", rf[16], 32'd0);
    rf_init();

    // 6) long stall on the header
    fill(32'h0000_0600, 2);
    start_frame(32'h0000_0600, 1'b0);
    consume(0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
